id_ex_pipeline_ctrl: RTL and testbench
======================================

ID_EX_PIPELINE_CTRL -- requirements
Module: id_ex_pipeline_ctrl

Interface
REQ-001 Parameter STALL_CYCLES, default 1, load-use bubble count per hazard; legal range 1..3.
REQ-002 Parameter CNT_WIDTH, default 16, width of the stall performance counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 id_valid  input  1  ID holds a real instruction this cycle.
REQ-006 id_instruction, id_data_a, id_data_b  input  cpu_width+1 each  decoded instruction and operands from ID.
REQ-007 id_destination_register, id_rs1, id_rs2  input  reg_addr_width+1 each  rd and source register addresses.
REQ-008 id_uses_rs1, id_uses_rs2  input  1 each  instruction actually reads rs1/rs2.
REQ-009 id_control  input  5  control bundle {alu_use_immediate, memory_read, memory_write, write_rd, write_register}.
REQ-010 mem_busy  input  1  memory stage not ready; freeze the EX side.
REQ-011 branch_taken  input  1  EX resolved a taken branch/jump this cycle.
REQ-012 ex_valid  output  1  EX-side register holds a real instruction.
REQ-013 ex_instruction, ex_data_a, ex_data_b, ex_destination_register, ex_control  output  widths as ID counterparts  registered EX-side copies.
REQ-014 stall_front  output  1  combinational; IF and ID SHALL hold when high.
REQ-015 flush_front  output  1  combinational; IF/ID SHALL discard their contents when high.
REQ-016 stall_count  output  CNT_WIDTH  cycles with stall_front high, saturating.

Function
REQ-017 Load-use hazard SHALL be id_valid & ex_valid & ex_control.memory_read & ex_control.write_register & ex_destination_register!=0 & ((id_uses_rs1 & id_rs1==ex_destination_register) | (id_uses_rs2 & id_rs2==ex_destination_register)).
REQ-018 Per cycle, priority SHALL be: reset > mem_busy > branch_taken > hazard or bubble_cnt!=0 > advance.
REQ-019 mem_busy: all ex_* registers and bubble_cnt SHALL hold; stall_front=1; flush_front=0 even if branch_taken (branch acted on after mem_busy drops).
REQ-020 branch_taken (mem_busy=0): next cycle ex_valid=0, ex data fields unchanged; flush_front=1; stall_front=0; bubble_cnt cleared to 0.
REQ-021 Hazard with bubble_cnt=0: ex_valid<=0, stall_front=1, bubble_cnt<=STALL_CYCLES-1.
REQ-022 bubble_cnt!=0: ex_valid<=0, stall_front=1, bubble_cnt decrements by 1.
REQ-023 Advance: all ex_* fields <= id_* fields, ex_valid<=id_valid; latency from ID to EX exactly one cycle.
REQ-024 A bubble SHALL leave ex data fields unchanged; only ex_valid is cleared; downstream gates on ex_valid.
REQ-025 Register x0 never creates a hazard; stall_count SHALL stick at 2^CNT_WIDTH-1.

Reset
REQ-026 On reset: ex_valid=0, all ex_* fields=0, bubble_cnt=0, stall_count=0; hence stall_front=0 and flush_front=0 the same cycle reset is high.
REQ-027 Reset mid-stall or mid-bubble SHALL abandon the sequence; first post-reset cycle is a normal advance.

Structure
REQ-028 cpu_width, reg_addr_width and the packed 5-bit control struct SHALL live in kamacore_pkg, shared with ID and EX stages.
REQ-029 Hazard detection SHALL be a combinational sub-module kamacore_hazard_detect; register, counter and priority logic stay in id_ex_pipeline_ctrl.

Verification
REQ-030 Advance: id_valid=1, id_instruction=0x00A00093, id_data_a=5 -> next cycle ex_valid=1, ex_instruction=0x00A00093, ex_data_a=5, stall_front=0.
REQ-031 Load-use: EX holds load rd=3 (memory_read=1, write_register=1), ID uses rs1=3 -> stall_front=1 one cycle, ex_valid=0, ID instruction reaches EX one cycle later.
REQ-032 STALL_CYCLES=3, same hazard -> exactly 3 bubble cycles, stall_front high 3 cycles, stall_count increments by 3.
REQ-033 Branch during hazard: branch_taken=1 and load-use both true -> flush_front=1, stall_front=0, ex_valid=0 next cycle, bubble_cnt=0.
REQ-034 mem_busy=1 for 4 cycles with branch_taken=1 -> ex_* frozen, flush_front=0; on mem_busy=0 flush_front=1 that cycle.
REQ-035 Reset asserted during 2nd bubble of STALL_CYCLES=3 -> all outputs 0 next cycle; load with rd=0 plus ID rs1=0 -> no stall.

Source files
------------

// File: rtl/kamacore_pkg.sv
// Shared KamaCore definitions for the ID, EX and ID/EX control stages.
// Widths are expressed as MSB indices, so a data word is [cpu_width:0].
package kamacore_pkg;

  localparam int cpu_width      = 31;
  localparam int reg_addr_width = 4;

  typedef struct packed {
    logic alu_use_immediate;
    logic memory_read;
    logic memory_write;
    logic write_rd;
    logic write_register;
  } control_t;

  // What the EX-side register does on a given cycle, in priority order.
  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_FLUSH,
    ACT_BUBBLE,
    ACT_ADVANCE
  } ex_action_e;

endpackage

// File: rtl/kamacore_hazard_detect.sv
// Combinational load-use detector: the instruction in ID reads a register
// that the load currently in EX has not yet produced.
module kamacore_hazard_detect
  import kamacore_pkg::*;
(
  input  logic                    id_valid,
  input  logic [reg_addr_width:0] id_rs1,
  input  logic [reg_addr_width:0] id_rs2,
  input  logic                    id_uses_rs1,
  input  logic                    id_uses_rs2,
  input  logic                    ex_valid,
  input  logic                    ex_memory_read,
  input  logic                    ex_write_register,
  input  logic [reg_addr_width:0] ex_destination_register,
  output logic                    load_use_hazard
);

  logic ex_is_load;
  logic rs1_match;
  logic rs2_match;

  // x0 is hardwired to zero, so a load targeting it never blocks anyone.
  assign ex_is_load = ex_valid && ex_memory_read && ex_write_register &&
                      (ex_destination_register != '0);
  assign rs1_match  = id_uses_rs1 && (id_rs1 == ex_destination_register);
  assign rs2_match  = id_uses_rs2 && (id_rs2 == ex_destination_register);

  assign load_use_hazard = id_valid && ex_is_load && (rs1_match || rs2_match);

endmodule

// File: rtl/id_ex_pipeline_ctrl.sv
// ID/EX pipeline register with load-use bubbling, branch flush, memory-stall
// freeze and a saturating count of front-end stall cycles.
module id_ex_pipeline_ctrl
  import kamacore_pkg::*;
#(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    id_valid,
  input  logic [cpu_width:0]      id_instruction,
  input  logic [cpu_width:0]      id_data_a,
  input  logic [cpu_width:0]      id_data_b,
  input  logic [reg_addr_width:0] id_destination_register,
  input  logic [reg_addr_width:0] id_rs1,
  input  logic [reg_addr_width:0] id_rs2,
  input  logic                    id_uses_rs1,
  input  logic                    id_uses_rs2,
  input  control_t                id_control,
  input  logic                    mem_busy,
  input  logic                    branch_taken,
  output logic                    ex_valid,
  output logic [cpu_width:0]      ex_instruction,
  output logic [cpu_width:0]      ex_data_a,
  output logic [cpu_width:0]      ex_data_b,
  output logic [reg_addr_width:0] ex_destination_register,
  output control_t                ex_control,
  output logic                    stall_front,
  output logic                    flush_front,
  output logic [CNT_WIDTH-1:0]    stall_count
);

  logic [1:0]  bubble_cnt;
  logic        load_use_hazard;
  ex_action_e  action;

  kamacore_hazard_detect u_hazard_detect (
    .id_valid                (id_valid),
    .id_rs1                  (id_rs1),
    .id_rs2                  (id_rs2),
    .id_uses_rs1             (id_uses_rs1),
    .id_uses_rs2             (id_uses_rs2),
    .ex_valid                (ex_valid),
    .ex_memory_read          (ex_control.memory_read),
    .ex_write_register       (ex_control.write_register),
    .ex_destination_register (ex_destination_register),
    .load_use_hazard         (load_use_hazard)
  );

  // A pending branch is deliberately ignored while memory is busy; it is
  // still asserted by EX once the freeze lifts and gets acted on then.
  always_comb begin
    action = ACT_ADVANCE;
    if (mem_busy) begin
      action = ACT_HOLD;
    end else if (branch_taken) begin
      action = ACT_FLUSH;
    end else if (load_use_hazard || (bubble_cnt != 2'd0)) begin
      action = ACT_BUBBLE;
    end
  end

  assign stall_front = !reset && ((action == ACT_HOLD) || (action == ACT_BUBBLE));
  assign flush_front = !reset && (action == ACT_FLUSH);

  // Bubbles and flushes only clear ex_valid; the data fields keep their last
  // contents because everything downstream qualifies on ex_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid                <= 1'b0;
      ex_instruction          <= '0;
      ex_data_a               <= '0;
      ex_data_b               <= '0;
      ex_destination_register <= '0;
      ex_control              <= '0;
      bubble_cnt              <= 2'd0;
    end else begin
      case (action)
        ACT_HOLD: begin
        end
        ACT_FLUSH: begin
          ex_valid   <= 1'b0;
          bubble_cnt <= 2'd0;
        end
        ACT_BUBBLE: begin
          ex_valid   <= 1'b0;
          bubble_cnt <= (bubble_cnt == 2'd0) ? 2'(STALL_CYCLES - 1)
                                             : bubble_cnt - 2'd1;
        end
        ACT_ADVANCE: begin
          ex_valid                <= id_valid;
          ex_instruction          <= id_instruction;
          ex_data_a               <= id_data_a;
          ex_data_b               <= id_data_b;
          ex_destination_register <= id_destination_register;
          ex_control              <= id_control;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall_front && (stall_count != {CNT_WIDTH{1'b1}})) begin
      stall_count <= stall_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_pipeline_ctrl.sv
// Bench for id_ex_pipeline_ctrl: two instances (1-bubble/16-bit counter and
// 3-bubble/4-bit counter) share stimulus and are compared to a cycle model.
module tb_id_ex_pipeline_ctrl;

  typedef struct packed {
    logic        reset;
    logic        id_valid;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        uses_rs1;
    logic        uses_rs2;
    logic [4:0]  ctrl;
    logic        mem_busy;
    logic        branch;
  } in_t;

  typedef struct {
    bit          valid;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [4:0]  ctrl;
    int          pending;
    int          count;
    int          cmax;
    int          stall_cycles;
  } model_t;

  localparam logic [4:0] LOAD_CTRL = 5'b01001;
  localparam logic [4:0] ALU_CTRL  = 5'b00011;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_instruction, id_data_a, id_data_b;
  logic [4:0]  id_destination_register, id_rs1, id_rs2;
  logic        id_uses_rs1, id_uses_rs2;
  logic [4:0]  id_control;
  logic        mem_busy, branch_taken;

  logic        ex_valid0, ex_valid1;
  logic [31:0] ex_instruction0, ex_instruction1;
  logic [31:0] ex_data_a0, ex_data_a1, ex_data_b0, ex_data_b1;
  logic [4:0]  ex_destination_register0, ex_destination_register1;
  logic [4:0]  ex_control0, ex_control1;
  logic        stall_front0, stall_front1, flush_front0, flush_front1;
  logic [15:0] stall_count0;
  logic [3:0]  stall_count1;

  int     tests = 0;
  int     fails = 0;
  model_t m0, m1;
  in_t    v;
  logic   last_stall0, last_stall1, last_flush0, last_flush1;

  always #5 clk = ~clk;

  id_ex_pipeline_ctrl #(.STALL_CYCLES(1), .CNT_WIDTH(16)) dut0 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_instruction(id_instruction),
    .id_data_a(id_data_a), .id_data_b(id_data_b),
    .id_destination_register(id_destination_register), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_control(id_control),
    .mem_busy(mem_busy), .branch_taken(branch_taken), .ex_valid(ex_valid0),
    .ex_instruction(ex_instruction0), .ex_data_a(ex_data_a0), .ex_data_b(ex_data_b0),
    .ex_destination_register(ex_destination_register0), .ex_control(ex_control0),
    .stall_front(stall_front0), .flush_front(flush_front0), .stall_count(stall_count0)
  );

  id_ex_pipeline_ctrl #(.STALL_CYCLES(3), .CNT_WIDTH(4)) dut1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_instruction(id_instruction),
    .id_data_a(id_data_a), .id_data_b(id_data_b),
    .id_destination_register(id_destination_register), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_control(id_control),
    .mem_busy(mem_busy), .branch_taken(branch_taken), .ex_valid(ex_valid1),
    .ex_instruction(ex_instruction1), .ex_data_a(ex_data_a1), .ex_data_b(ex_data_b1),
    .ex_destination_register(ex_destination_register1), .ex_control(ex_control1),
    .stall_front(stall_front1), .flush_front(flush_front1), .stall_count(stall_count1)
  );

  // Reference model: EX holds the last instruction that was allowed through,
  // "pending" counts the bubbles still owed to the current load-use hazard.
  function automatic bit model_hazard(model_t m, in_t i);
    bit reads_rd;
    reads_rd = (i.uses_rs1 && i.rs1 == m.rd) || (i.uses_rs2 && i.rs2 == m.rd);
    return i.id_valid && m.valid && m.ctrl[3] && m.ctrl[0] && (m.rd != 0) && reads_rd;
  endfunction

  function automatic bit model_stall(model_t m, in_t i);
    if (i.reset) return 1'b0;
    if (i.mem_busy) return 1'b1;
    if (i.branch) return 1'b0;
    return (m.pending > 0) || model_hazard(m, i);
  endfunction

  function automatic bit model_flush(in_t i);
    return !i.reset && !i.mem_busy && i.branch;
  endfunction

  function automatic model_t model_next(model_t m, in_t i);
    model_t n = m;
    int owed;
    if (i.reset) begin
      n.valid = 0; n.instr = '0; n.a = '0; n.b = '0; n.rd = '0; n.ctrl = '0;
      n.pending = 0; n.count = 0;
      return n;
    end
    if (model_stall(m, i) && n.count < n.cmax) n.count = n.count + 1;
    if (i.mem_busy) return n;
    if (i.branch) begin
      n.valid = 0;
      n.pending = 0;
    end else if (m.pending > 0 || model_hazard(m, i)) begin
      owed = (m.pending > 0) ? m.pending : m.stall_cycles;
      n.pending = owed - 1;
      n.valid = 0;
    end else begin
      n.valid = i.id_valid; n.instr = i.instr; n.a = i.a; n.b = i.b;
      n.rd = i.rd; n.ctrl = i.ctrl;
    end
    return n;
  endfunction

  task automatic check(string tag, logic [31:0] observed, logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(string tag);
    check({tag, "/ex_valid0"}, 32'(ex_valid0), 32'(m0.valid));
    check({tag, "/ex_instr0"}, ex_instruction0, m0.instr);
    check({tag, "/ex_a0"}, ex_data_a0, m0.a);
    check({tag, "/ex_b0"}, ex_data_b0, m0.b);
    check({tag, "/ex_rd0"}, 32'(ex_destination_register0), 32'(m0.rd));
    check({tag, "/ex_ctrl0"}, 32'(ex_control0), 32'(m0.ctrl));
    check({tag, "/count0"}, 32'(stall_count0), 32'(m0.count));
    check({tag, "/ex_valid1"}, 32'(ex_valid1), 32'(m1.valid));
    check({tag, "/ex_instr1"}, ex_instruction1, m1.instr);
    check({tag, "/ex_a1"}, ex_data_a1, m1.a);
    check({tag, "/ex_b1"}, ex_data_b1, m1.b);
    check({tag, "/ex_rd1"}, 32'(ex_destination_register1), 32'(m1.rd));
    check({tag, "/ex_ctrl1"}, 32'(ex_control1), 32'(m1.ctrl));
    check({tag, "/count1"}, 32'(stall_count1), 32'(m1.count));
  endtask

  // One clock cycle: drive, check combinational outputs before the edge,
  // advance the model, check registered outputs just after the edge.
  task automatic applyStimulus(in_t i, string tag);
    reset = i.reset; id_valid = i.id_valid; id_instruction = i.instr;
    id_data_a = i.a; id_data_b = i.b; id_destination_register = i.rd;
    id_rs1 = i.rs1; id_rs2 = i.rs2; id_uses_rs1 = i.uses_rs1; id_uses_rs2 = i.uses_rs2;
    id_control = i.ctrl; mem_busy = i.mem_busy; branch_taken = i.branch;
    #3;
    last_stall0 = stall_front0; last_flush0 = flush_front0;
    last_stall1 = stall_front1; last_flush1 = flush_front1;
    check({tag, "/stall0"}, 32'(stall_front0), 32'(model_stall(m0, i)));
    check({tag, "/flush0"}, 32'(flush_front0), 32'(model_flush(i)));
    check({tag, "/stall1"}, 32'(stall_front1), 32'(model_stall(m1, i)));
    check({tag, "/flush1"}, 32'(flush_front1), 32'(model_flush(i)));
    @(posedge clk);
    #1;
    m0 = model_next(m0, i);
    m1 = model_next(m1, i);
    checkOutput(tag);
  endtask

  function automatic in_t load_insn(logic [4:0] rd);
    in_t i = '0;
    i.id_valid = 1'b1; i.instr = 32'h0000_2003 | {20'h0, rd, 7'h0}; i.a = 32'h100;
    i.rd = rd; i.ctrl = LOAD_CTRL;
    return i;
  endfunction

  function automatic in_t use_insn(logic [4:0] rs1);
    in_t i = '0;
    i.id_valid = 1'b1; i.instr = 32'h0031_8233; i.a = 32'h77; i.b = 32'h88;
    i.rd = 5'd4; i.rs1 = rs1; i.uses_rs1 = 1'b1; i.ctrl = ALU_CTRL;
    return i;
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    m0 = '{valid: 0, instr: '0, a: '0, b: '0, rd: '0, ctrl: '0,
           pending: 0, count: 0, cmax: 65535, stall_cycles: 1};
    m1 = '{valid: 0, instr: '0, a: '0, b: '0, rd: '0, ctrl: '0,
           pending: 0, count: 0, cmax: 15, stall_cycles: 3};

    v = '0; v.reset = 1'b1;
    applyStimulus(v, "reset_a");
    applyStimulus(v, "reset_b");
    check("reset_stall0", 32'(last_stall0), 32'd0);
    check("reset_flush0", 32'(last_flush0), 32'd0);

    v = '0; v.id_valid = 1'b1; v.instr = 32'h00A0_0093; v.a = 32'd5;
    applyStimulus(v, "advance");
    check("advance_valid", 32'(ex_valid0), 32'd1);
    check("advance_instr", ex_instruction0, 32'h00A0_0093);
    check("advance_a", ex_data_a0, 32'd5);
    check("advance_stall", 32'(last_stall0), 32'd0);

    applyStimulus(load_insn(5'd3), "lu_load");
    v = use_insn(5'd3);
    applyStimulus(v, "lu_a");
    check("lu_stall0", 32'(last_stall0), 32'd1);
    check("lu_bubble0", 32'(ex_valid0), 32'd0);
    applyStimulus(v, "lu_b");
    check("lu_unstall0", 32'(last_stall0), 32'd0);
    check("lu_arrive0", ex_instruction0, 32'h0031_8233);
    check("lu_arrive_valid0", 32'(ex_valid0), 32'd1);
    applyStimulus(v, "lu_c");
    applyStimulus(v, "lu_d");
    check("lu3_stall_total", 32'(stall_count1), 32'd3);
    check("lu3_arrive", 32'(ex_valid1), 32'd1);
    check("lu1_stall_total", 32'(stall_count0), 32'd1);

    applyStimulus(load_insn(5'd3), "br_load");
    v = use_insn(5'd3); v.branch = 1'b1;
    applyStimulus(v, "br_hazard");
    check("br_flush0", 32'(last_flush0), 32'd1);
    check("br_stall0", 32'(last_stall0), 32'd0);
    check("br_valid1", 32'(ex_valid1), 32'd0);
    v.branch = 1'b0;
    applyStimulus(v, "br_after");
    check("br_nobubble1", 32'(last_stall1), 32'd0);

    applyStimulus(load_insn(5'd5), "mb_load");
    v = use_insn(5'd9); v.mem_busy = 1'b1; v.branch = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(v, "mb_busy");
      check("mb_noflush", 32'(last_flush0), 32'd0);
      check("mb_frozen", ex_instruction0, 32'h0000_2283);
    end
    v.mem_busy = 1'b0;
    applyStimulus(v, "mb_release");
    check("mb_flush", 32'(last_flush0), 32'd1);

    v.mem_busy = 1'b1; v.branch = 1'b0;
    for (int k = 0; k < 16; k++) applyStimulus(v, "sat");
    check("sat_count1", 32'(stall_count1), 32'd15);

    applyStimulus(load_insn(5'd3), "rst_load");
    v = use_insn(5'd3);
    applyStimulus(v, "rst_bubble1");
    v.reset = 1'b1;
    applyStimulus(v, "rst_bubble2");
    check("rst_stall1", 32'(last_stall1), 32'd0);
    check("rst_valid1", 32'(ex_valid1), 32'd0);
    check("rst_instr1", ex_instruction1, 32'd0);
    check("rst_count1", 32'(stall_count1), 32'd0);
    applyStimulus(load_insn(5'd0), "x0_load");
    check("x0_post_reset_advance", 32'(ex_valid1), 32'd1);
    applyStimulus(use_insn(5'd0), "x0_use");
    check("x0_nostall0", 32'(last_stall0), 32'd0);
    check("x0_nostall1", 32'(last_stall1), 32'd0);

    for (int k = 0; k < 600; k++) begin
      v = '0;
      v.reset    = ($urandom_range(0, 63) == 0);
      v.id_valid = ($urandom_range(0, 3) != 0);
      v.instr    = $urandom;
      v.a        = $urandom;
      v.b        = $urandom;
      v.rd       = 5'($urandom_range(0, 3));
      v.rs1      = 5'($urandom_range(0, 3));
      v.rs2      = 5'($urandom_range(0, 3));
      v.uses_rs1 = 1'($urandom_range(0, 1));
      v.uses_rs2 = 1'($urandom_range(0, 1));
      v.ctrl     = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) v.ctrl = v.ctrl | LOAD_CTRL;
      v.mem_busy = ($urandom_range(0, 5) == 0);
      v.branch   = ($urandom_range(0, 7) == 0);
      applyStimulus(v, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
